// File: rtl/icache_pkg.sv
// icache_pkg
//   Shared constants and types for the instruction cache refill block:
//   default geometry, bus widths, FSM state encoding and a tag-width helper.
package icache_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Tag bits left over once the word offset and line index are removed.
  function automatic int tag_width(input int lines, input int words);
    return ADDR_W - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_refill_if.sv
// icache_mem_if
//   Line-refill bus between the instruction cache (master) and backing
//   memory (slave).
//   req    : line read request, held until ack
//   addr   : line-aligned word address
//   ack    : request accepted
//   rvalid : one data beat on rdata
//   rdata  : refill word, ascending offset order
interface icache_mem_if;
  import icache_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rvalid, input rdata);
  modport slave  (input req, input addr, output ack, output rvalid, output rdata);

endinterface

// File: rtl/icache_line_array.sv
// icache_line_array
//   Valid/tag/data storage for a direct-mapped cache.
//   clk, reset : clock, async active-high reset (clears valid bits only)
//   clr        : clear all valid bits on the next edge
//   we         : write one full line (data, tag, valid) at wr_index
//   rd_index   : combinational read of valid/tag/line
module icache_line_array
  import icache_pkg::*;
#(
  parameter int LINES   = LINES_DEF,
  parameter int WORDS   = WORDS_DEF,
  parameter int INDEX_W = $clog2(LINES),
  parameter int TAG_W   = tag_width(LINES, WORDS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          we,
  input  logic [INDEX_W-1:0]            wr_index,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic                          wr_valid,
  input  logic [WORDS-1:0][DATA_W-1:0]  wr_line,
  input  logic [INDEX_W-1:0]            rd_index,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [WORDS-1:0][DATA_W-1:0]  rd_line
);

  logic [LINES-1:0]               valid_q;
  logic [TAG_W-1:0]               tag_q  [LINES];
  logic [WORDS-1:0][DATA_W-1:0]   data_q [LINES];

  // clr wins over a same-cycle line write, so an invalidate racing the
  // final write still leaves the line invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/icache_refill.sv
// icache_refill
//   Direct-mapped instruction cache with miss/refill FSM feeding the IF stage.
//   clk, reset     : clock, async active-high reset
//   pc_addr        : word address of fetch
//   fetch_en       : lookup request this cycle
//   invalidate     : clear all valid bits (fence.i)
//   inst/inst_valid: hit data, zero-latency, 0 when not valid
//   stall          : hold PC and IF_ID
//   mem            : line refill bus (master side)
//   miss_cnt       : saturating miss count
//
//   state   | meaning
//   IDLE    | lookups active, a miss latches the line address
//   REQ     | mem.req high with stable address, waiting for ack
//   FILL    | collecting WORDS beats into the line buffer
//   DONE    | write buffer/tag into the array, then back to IDLE
module icache_refill
  import icache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               fetch_en,
  input  logic               invalidate,
  output logic [DATA_W-1:0]  inst,
  output logic               inst_valid,
  output logic               stall,
  icache_mem_if.master       mem,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int OFFSET_W = $clog2(WORDS);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int TAG_W    = tag_width(LINES, WORDS);

  state_t                        state;
  logic [OFFSET_W-1:0]           beat;
  logic [WORDS-1:0][DATA_W-1:0]  line_buf;
  logic [ADDR_W-1:0]             miss_addr;
  logic                          inval_pending;
  logic                          mem_req_q;

  logic [OFFSET_W-1:0]           pc_offset;
  logic [INDEX_W-1:0]            pc_index;
  logic [TAG_W-1:0]              pc_tag;
  logic                          rd_valid;
  logic [TAG_W-1:0]              rd_tag;
  logic [WORDS-1:0][DATA_W-1:0]  rd_line;
  logic                          hit;
  logic                          miss;

  assign pc_offset = pc_addr[OFFSET_W-1:0];
  assign pc_index  = pc_addr[OFFSET_W +: INDEX_W];
  assign pc_tag    = pc_addr[ADDR_W-1 -: TAG_W];

  icache_line_array #(
    .LINES   (LINES),
    .WORDS   (WORDS),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .clr      (invalidate),
    .we       (state == ST_DONE),
    .wr_index (miss_addr[OFFSET_W +: INDEX_W]),
    .wr_tag   (miss_addr[ADDR_W-1 -: TAG_W]),
    .wr_valid (~inval_pending & ~invalidate),
    .wr_line  (line_buf),
    .rd_index (pc_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line)
  );

  // Lookup is combinational so a hit costs no extra cycle; it only counts
  // in IDLE since the array may be mid-update otherwise.
  assign hit        = fetch_en & rd_valid & (rd_tag == pc_tag) & (state == ST_IDLE);
  assign miss       = fetch_en & ~hit & (state == ST_IDLE);
  assign inst_valid = hit;
  assign inst       = hit ? rd_line[pc_offset] : '0;
  assign stall      = (fetch_en & ~hit) | (state != ST_IDLE);

  assign mem.req  = mem_req_q;
  assign mem.addr = miss_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      beat          <= '0;
      line_buf      <= '0;
      miss_addr     <= '0;
      miss_cnt      <= '0;
      inval_pending <= 1'b0;
      mem_req_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss) begin
            miss_addr <= {pc_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            mem_req_q <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (invalidate) inval_pending <= 1'b1;
          if (mem.ack) begin
            mem_req_q <= 1'b0;
            beat      <= '0;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (invalidate) inval_pending <= 1'b1;
          if (mem.rvalid) begin
            line_buf[beat] <= mem.rdata;
            beat           <= beat + OFFSET_W'(1);
            if (beat == OFFSET_W'(WORDS - 1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          inval_pending <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
